// File: rtl/pool2x2_stream.sv
// Streaming 2x2/stride-2 max-pool stage with optional ReLU, output saturation
// and a pool-bypass mode. Input order is row, col, channel (channel fastest).
// Assumes IN_W > OUT_W.
module pool2x2_stream #(
    parameter int unsigned IN_W     = 21,
    parameter int unsigned OUT_W    = 15,
    parameter int unsigned MAX_COLS = 24,
    parameter int unsigned MAX_ROWS = 24,
    parameter int unsigned CH       = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [$clog2(MAX_COLS+1)-1:0]        cfg_cols,
    input  logic [$clog2(MAX_ROWS+1)-1:0]        cfg_rows,
    input  logic                                 cfg_relu,
    input  logic                                 cfg_bypass,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic signed [IN_W-1:0]               in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic signed [OUT_W-1:0]              out_data,
    output logic                                 out_last,
    output logic                                 busy,
    output logic                                 done
);

    localparam int unsigned CW      = $clog2(MAX_COLS + 1);
    localparam int unsigned RW      = $clog2(MAX_ROWS + 1);
    localparam int unsigned CHW     = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned PAIR_N  = 2 ** CHW;
    localparam int unsigned LB_USED = ((MAX_COLS / 2) > 0 ? (MAX_COLS / 2) : 1) * CH;
    localparam int unsigned LBW     = (LB_USED > 1) ? $clog2(LB_USED) : 1;
    localparam int unsigned LB_N    = 2 ** LBW;

    localparam logic [CHW-1:0]         CH_LAST = CHW'(CH - 1);
    localparam logic signed [IN_W-1:0] SAT_HI  = IN_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [IN_W-1:0] SAT_LO  = ~SAT_HI;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t                  state_q,    state_d;
    logic [CW-1:0]           cols_q,     cols_d;
    logic [RW-1:0]           rows_q,     rows_d;
    logic                    relu_q,     relu_d;
    logic                    bypass_q,   bypass_d;
    logic [RW-1:0]           row_q,      row_d;
    logic [CW-1:0]           col_q,      col_d;
    logic [CHW-1:0]          ch_q,       ch_d;
    logic signed [IN_W-1:0]  pair_q [PAIR_N];
    logic signed [IN_W-1:0]  pair_d [PAIR_N];
    logic                    out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0] out_data_q,  out_data_d;
    logic                    out_last_q,  out_last_d;
    logic                    busy_q,      busy_d;
    logic                    done_q,      done_d;

    // Line buffer holds horizontal maxima of the even row; contents need no reset.
    logic signed [IN_W-1:0]  lb_mem [LB_N];

    logic                    accept_c;
    logic                    cfg_bad_c;
    logic signed [IN_W-1:0]  v_c;
    logic signed [IN_W-1:0]  h_c;
    logic signed [IN_W-1:0]  lb_rd_c;
    logic signed [IN_W-1:0]  m_c;
    logic [LBW-1:0]          lb_idx_c;
    logic                    lb_we_c;
    logic                    last_ch_c;
    logic                    frame_end_c;
    logic                    pool_last_c;

    // Clamp a wide signed value into the output range.
    function automatic logic signed [OUT_W-1:0] sat(input logic signed [IN_W-1:0] x);
        logic signed [IN_W-1:0] y;
        if (x > SAT_HI) begin
            y = SAT_HI;
        end else if (x < SAT_LO) begin
            y = SAT_LO;
        end else begin
            y = x;
        end
        return y[OUT_W-1:0];
    endfunction

    // Accept while running unless a stalled result still occupies the output register.
    assign in_ready  = (state_q == S_RUN) && !(out_valid_q && !out_ready);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Datapath: ReLU, horizontal/vertical maxima and frame-position flags.
    always_comb begin
        accept_c    = in_valid && in_ready;
        cfg_bad_c   = (cfg_cols == '0) || (cfg_rows == '0) ||
                      (cfg_cols > CW'(MAX_COLS)) || (cfg_rows > RW'(MAX_ROWS));
        v_c         = (relu_q && in_data[IN_W-1]) ? '0 : in_data;
        h_c         = (pair_q[ch_q] > v_c) ? pair_q[ch_q] : v_c;
        lb_idx_c    = LBW'((32'(col_q) >> 1) * CH + 32'(ch_q));
        lb_rd_c     = lb_mem[lb_idx_c];
        m_c         = (lb_rd_c > h_c) ? lb_rd_c : h_c;
        last_ch_c   = (ch_q == CH_LAST);
        frame_end_c = last_ch_c && (col_q == cols_q - CW'(1)) && (row_q == rows_q - RW'(1));
        pool_last_c = last_ch_c &&
                      (col_q == (cols_q & ~CW'(1)) - CW'(1)) &&
                      (row_q == (rows_q & ~RW'(1)) - RW'(1));
    end

    // Next-state, counters, pair registers and output register.
    always_comb begin
        state_d     = state_q;
        cols_d      = cols_q;
        rows_d      = rows_q;
        relu_d      = relu_q;
        bypass_d    = bypass_q;
        row_d       = row_q;
        col_d       = col_q;
        ch_d        = ch_q;
        pair_d      = pair_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        lb_we_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cols_d   = cfg_cols;
                    rows_d   = cfg_rows;
                    relu_d   = cfg_relu;
                    bypass_d = cfg_bypass;
                    row_d    = '0;
                    col_d    = '0;
                    ch_d     = '0;
                    state_d  = cfg_bad_c ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                if (accept_c) begin
                    if (last_ch_c) begin
                        ch_d = '0;
                        if (col_q == cols_q - CW'(1)) begin
                            col_d = '0;
                            row_d = row_q + RW'(1);
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                    end else begin
                        ch_d = ch_q + CHW'(1);
                    end

                    if (bypass_q) begin
                        out_valid_d = 1'b1;
                        out_data_d  = sat(v_c);
                        out_last_d  = frame_end_c;
                    end else if (!col_q[0]) begin
                        pair_d[ch_q] = v_c;
                    end else if (!row_q[0]) begin
                        lb_we_c = 1'b1;
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = sat(m_c);
                        out_last_d  = pool_last_c;
                    end

                    if (frame_end_c) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!out_valid_q || out_ready) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIN);
    end

    // State and control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cols_q      <= '0;
            rows_q      <= '0;
            relu_q      <= 1'b0;
            bypass_q    <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            ch_q        <= '0;
            pair_q      <= '{default: '0};
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cols_q      <= cols_d;
            rows_q      <= rows_d;
            relu_q      <= relu_d;
            bypass_q    <= bypass_d;
            row_q       <= row_d;
            col_q       <= col_d;
            ch_q        <= ch_d;
            pair_q      <= pair_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Line-buffer write of the even-row horizontal maximum.
    always_ff @(posedge clk) begin
        if (lb_we_c) begin
            lb_mem[lb_idx_c] <= h_c;
        end
    end

endmodule

// File: tb/tb_pool2x2_stream.sv
// Bench for pool2x2_stream: directed frames plus random frames on a CH=1 and a
// CH=2 instance, checked against a window-based reference model.
`timescale 1ns/1ps
module tb_pool2x2_stream;

    localparam int IN_W   = 21;
    localparam int OUT_W  = 15;
    localparam int MAXC   = 24;
    localparam int MAXR   = 24;
    localparam int CW     = $clog2(MAXC + 1);
    localparam int RW     = $clog2(MAXR + 1);
    localparam int OUT_HI = 2 ** (OUT_W - 1) - 1;
    localparam int OUT_LO = -(2 ** (OUT_W - 1));

    typedef struct packed {
        int   data;
        logic last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] start, cfg_relu, cfg_bypass, in_valid, in_ready;
    logic [1:0] out_valid, out_ready, out_last, busy, done;
    logic [CW-1:0]           cfg_cols [2];
    logic [RW-1:0]           cfg_rows [2];
    logic signed [IN_W-1:0]  in_data  [2];
    logic signed [OUT_W-1:0] out_data [2];

    int   n_chk = 0;
    int   n_fail = 0;
    int   frm[$];
    int   lit[$];
    exp_t exp_q[$];
    bit   comp[$];
    int   cur_d = 0;
    bit   mon_en = 1'b0;
    int   cyc = 0;
    int   done_cnt = 0;

    bit   load_pend, stall_pend, done_prev, busy_hi_pend, busy_lo_pend;
    logic signed [OUT_W-1:0] prev_data;
    logic prev_last;
    int   mon_beat, last_in, last_hs, m_d, exp_done;
    bit   m_fire;
    exp_t m_e;

    always #5 clk = ~clk;

    pool2x2_stream #(.IN_W(IN_W), .OUT_W(OUT_W), .MAX_COLS(MAXC), .MAX_ROWS(MAXR), .CH(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .cfg_cols(cfg_cols[0]), .cfg_rows(cfg_rows[0]),
        .cfg_relu(cfg_relu[0]), .cfg_bypass(cfg_bypass[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .in_data(in_data[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_data(out_data[0]), .out_last(out_last[0]),
        .busy(busy[0]), .done(done[0])
    );

    pool2x2_stream #(.IN_W(IN_W), .OUT_W(OUT_W), .MAX_COLS(MAXC), .MAX_ROWS(MAXR), .CH(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .cfg_cols(cfg_cols[1]), .cfg_rows(cfg_rows[1]),
        .cfg_relu(cfg_relu[1]), .cfg_bypass(cfg_bypass[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .in_data(in_data[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_data(out_data[1]), .out_last(out_last[1]),
        .busy(busy[1]), .done(done[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pre(input int x, input bit relu);
        return (relu && x < 0) ? 0 : x;
    endfunction

    function automatic int sat(input int x);
        if (x > OUT_HI) return OUT_HI;
        if (x < OUT_LO) return OUT_LO;
        return x;
    endfunction

    // Reference: each output is the saturated max over its 2x2 window of the frame.
    task automatic prep(input int ch, input int cols, input int rows, input bit relu, input bit byp);
        exp_t e;
        int n, pr, pc, c, col, row, m, v;
        exp_q.delete();
        comp.delete();
        if (cols < 1 || rows < 1 || cols > MAXC || rows > MAXR) return;
        n  = cols * rows * ch;
        pr = rows & ~1;
        pc = cols & ~1;
        for (int k = 0; k < n; k++) begin
            c   = k % ch;
            col = (k / ch) % cols;
            row = k / (ch * cols);
            if (byp) begin
                e.data = sat(pre(frm[k], relu));
                e.last = (k == n - 1);
                exp_q.push_back(e);
                comp.push_back(1'b1);
            end else if (row % 2 == 1 && col % 2 == 1 && row < pr && col < pc) begin
                m = pre(frm[k], relu);
                for (int dr = 0; dr < 2; dr++) begin
                    for (int dc = 0; dc < 2; dc++) begin
                        v = pre(frm[((row - 1 + dr) * cols + (col - 1 + dc)) * ch + c], relu);
                        if (v > m) m = v;
                    end
                end
                e.data = sat(m);
                e.last = (row == pr - 1 && col == pc - 1 && c == ch - 1);
                exp_q.push_back(e);
                comp.push_back(1'b1);
            end else begin
                comp.push_back(1'b0);
            end
        end
    endtask

    // Compare the model's expectation list with hand-computed values.
    task automatic pin(input string name);
        chk({name, "_count"}, exp_q.size(), lit.size());
        for (int i = 0; i < lit.size() && i < exp_q.size(); i++) chk(name, exp_q[i].data, lit[i]);
        if (exp_q.size() > 0) chk({name, "_last"}, int'(exp_q[exp_q.size() - 1].last), 1);
    endtask

    task automatic ramp(input int n, input int base);
        frm.delete();
        for (int i = 0; i < n; i++) frm.push_back(base + i);
    endtask

    task automatic run_frame(input int d, input int cols, input int rows, input bit relu, input bit byp,
                             input int vpct, input int rpct, input int stall_from, input int stall_len);
        int n, idx, t, d0;
        bit fire, ok;
        ok  = cols >= 1 && rows >= 1 && cols <= MAXC && rows <= MAXR;
        n   = ok ? cols * rows * (d + 1) : 0;
        idx = 0;
        t   = 0;
        cur_d  = d;
        d0     = done_cnt;
        mon_en = 1'b1;
        cfg_cols[d]   = CW'(cols);
        cfg_rows[d]   = RW'(rows);
        cfg_relu[d]   = relu;
        cfg_bypass[d] = byp;
        start[d]      = 1'b1;
        @(posedge clk); #1;
        start[d] = 1'b0;
        while ((idx < n || done_cnt == d0) && t < 20000) begin
            in_valid[d] = (idx < n) && ($urandom_range(0, 99) < vpct);
            in_data[d]  = (idx < n) ? IN_W'(frm[idx]) : '0;
            if (stall_len > 0) out_ready[d] = !(t >= stall_from && t < stall_from + stall_len);
            else               out_ready[d] = ($urandom_range(0, 99) < rpct);
            @(negedge clk);
            fire = in_valid[d] && in_ready[d];
            @(posedge clk); #1;
            if (fire) idx++;
            t++;
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b0;
        chk("frame_beats", idx, n);
        chk("frame_done", done_cnt - d0, 1);
        chk("frame_outputs_left", exp_q.size(), 0);
    endtask

    // Cycle monitor: handshakes, load latency, hold under stall, done/busy timing.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            load_pend    = 1'b0;
            stall_pend   = 1'b0;
            done_prev    = 1'b0;
            busy_hi_pend = 1'b0;
            busy_lo_pend = 1'b0;
        end else if (mon_en) begin
            m_d = cur_d;
            if (busy_hi_pend) chk("busy_high", int'(busy[m_d]), 1);
            if (busy_lo_pend) chk("busy_low", int'(busy[m_d]), 0);
            busy_hi_pend = 1'b0;
            busy_lo_pend = 1'b0;
            if (start[m_d]) begin
                last_in      = cyc - 1;
                last_hs      = -100;
                mon_beat     = 0;
                busy_hi_pend = 1'b1;
            end
            if (load_pend) begin
                chk("load_valid", int'(out_valid[m_d]), 1);
                chk("load_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    chk("load_data", int'(out_data[m_d]), exp_q[0].data);
                    chk("load_last", int'(out_last[m_d]), int'(exp_q[0].last));
                end
            end
            if (stall_pend) begin
                chk("hold_valid", int'(out_valid[m_d]), 1);
                chk("hold_data", int'(out_data[m_d]), int'(prev_data));
                chk("hold_last", int'(out_last[m_d]), int'(prev_last));
            end
            if (out_valid[m_d] && !out_ready[m_d]) chk("in_ready_stall", int'(in_ready[m_d]), 0);
            if (out_valid[m_d] && out_ready[m_d]) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL extra_output: got %0d expected no output (t=%0t)", out_data[m_d], $time);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("out_data", int'(out_data[m_d]), m_e.data);
                    chk("out_last", int'(out_last[m_d]), int'(m_e.last));
                end
                last_hs = cyc;
            end
            m_fire    = in_valid[m_d] && in_ready[m_d];
            load_pend = 1'b0;
            if (m_fire) begin
                load_pend = (mon_beat < comp.size()) ? comp[mon_beat] : 1'b0;
                mon_beat++;
                last_in = cyc;
            end
            stall_pend = out_valid[m_d] && !out_ready[m_d];
            prev_data  = out_data[m_d];
            prev_last  = out_last[m_d];
            if (done[m_d]) begin
                exp_done = (last_in + 2 > last_hs + 1) ? last_in + 2 : last_hs + 1;
                chk("done_pulse", int'(done_prev), 0);
                chk("done_time", cyc, exp_done);
                chk("done_outputs_left", exp_q.size(), 0);
                done_cnt++;
                busy_lo_pend = 1'b1;
            end
            done_prev = done[m_d];
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cols, rows, d, vp, rp;
        bit relu, byp;
        start = '0; cfg_relu = '0; cfg_bypass = '0; in_valid = '0; out_ready = '0;
        for (int i = 0; i < 2; i++) begin
            cfg_cols[i] = '0; cfg_rows[i] = '0; in_data[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_in_ready", int'(in_ready[i]), 0);
            chk("reset_out_valid", int'(out_valid[i]), 0);
            chk("reset_out_data", int'(out_data[i]), 0);
            chk("reset_out_last", int'(out_last[i]), 0);
            chk("reset_busy", int'(busy[i]), 0);
            chk("reset_done", int'(done[i]), 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 4x4 raster, free-flowing
        ramp(16, 0); prep(1, 4, 4, 0, 0); lit = '{5, 7, 13, 15}; pin("model_4x4");
        run_frame(0, 4, 4, 0, 0, 100, 100, 0, 0);

        // ReLU on and off
        frm = '{-8, -3, -1, -20}; prep(1, 2, 2, 1, 0); lit = '{0}; pin("model_relu");
        run_frame(0, 2, 2, 1, 0, 100, 100, 0, 0);
        prep(1, 2, 2, 0, 0); lit = '{-1}; pin("model_norelu");
        run_frame(0, 2, 2, 0, 0, 100, 100, 0, 0);

        // Saturation both ways
        frm = '{40000, 40000, 40000, 40000}; prep(1, 2, 2, 0, 0); lit = '{16383}; pin("model_sat_hi");
        run_frame(0, 2, 2, 0, 0, 100, 100, 0, 0);
        frm = '{-40000, -40000, -40000, -40000}; prep(1, 2, 2, 0, 0); lit = '{-16384}; pin("model_sat_lo");
        run_frame(0, 2, 2, 0, 0, 100, 100, 0, 0);

        // Backpressure: out_ready low 5 cycles while the first result is pending
        ramp(16, 0); prep(1, 4, 4, 0, 0); lit = '{5, 7, 13, 15}; pin("model_stall");
        run_frame(0, 4, 4, 0, 0, 100, 100, 6, 5);

        // Bypass and odd-size pooling
        ramp(9, 1); prep(1, 3, 3, 0, 1); lit = '{1, 2, 3, 4, 5, 6, 7, 8, 9}; pin("model_bypass");
        run_frame(0, 3, 3, 0, 1, 100, 100, 0, 0);
        ramp(25, 0); prep(1, 5, 5, 0, 0); lit = '{6, 8, 16, 18}; pin("model_5x5");
        run_frame(0, 5, 5, 0, 0, 70, 70, 0, 0);

        // Two interleaved channels
        frm = '{1, 10, 2, 20, 3, 30, 4, 40}; prep(2, 2, 2, 0, 0); lit = '{4, 40}; pin("model_ch2");
        run_frame(1, 2, 2, 0, 0, 100, 100, 0, 0);

        // Degenerate and illegal sizes
        frm.delete(); prep(1, 0, 4, 0, 0); run_frame(0, 0, 4, 0, 0, 100, 100, 0, 0);
        prep(1, 25, 2, 0, 0); run_frame(0, 25, 2, 0, 0, 100, 100, 0, 0);
        ramp(4, 3); prep(1, 4, 1, 0, 0); chk("model_1row_empty", exp_q.size(), 0);
        run_frame(0, 4, 1, 0, 0, 100, 100, 0, 0);

        // Reset mid-frame with a result pending
        ramp(16, 0); prep(1, 4, 4, 0, 0);
        mon_en = 1'b0; cur_d = 0;
        cfg_cols[0] = CW'(4); cfg_rows[0] = RW'(4); cfg_relu[0] = 1'b0; cfg_bypass[0] = 1'b0;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0; in_valid[0] = 1'b1; out_ready[0] = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in_data[0] = IN_W'(i < 6 ? i : 6);
            @(posedge clk); #1;
        end
        chk("rst_pre_valid", int'(out_valid[0]), 1);
        chk("rst_pre_data", int'(out_data[0]), 5);
        chk("rst_pre_busy", int'(busy[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", int'(out_valid[0]), 0);
        chk("rst_async_data", int'(out_data[0]), 0);
        chk("rst_async_in_ready", int'(in_ready[0]), 0);
        chk("rst_async_busy", int'(busy[0]), 0);
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_no_done", int'(done[0]), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        prep(1, 4, 4, 0, 0);
        run_frame(0, 4, 4, 0, 0, 100, 100, 0, 0);

        // Random frames on both instances
        for (int it = 0; it < 40; it++) begin
            d    = int'($urandom_range(0, 1));
            cols = int'($urandom_range(1, (it % 10 == 0) ? 24 : 9));
            rows = int'($urandom_range(1, (it % 10 == 0) ? 24 : 9));
            relu = 1'($urandom_range(0, 1));
            byp  = ($urandom_range(0, 3) == 0);
            vp   = int'($urandom_range(50, 100));
            rp   = int'($urandom_range(30, 100));
            frm.delete();
            for (int k = 0; k < cols * rows * (d + 1); k++) begin
                if (it % 2 == 0) frm.push_back(int'($urandom_range(0, 40)) - 20);
                else             frm.push_back(int'($urandom_range(0, 199999)) - 100000);
            end
            prep(d + 1, cols, rows, relu, byp);
            run_frame(d, cols, rows, relu, byp, vp, rp, 0, 0);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
